// File: rtl/traffic_pkg.sv
// traffic_pkg: level/light encodings and the hysteretic density classifier shared by the traffic blocks
package traffic_pkg;
  typedef logic [1:0] level_t;
  localparam level_t LOW = 2'b00;
  localparam level_t MODERATE = 2'b01;
  localparam level_t HIGH = 2'b10;
  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN = 2'b10;
  // Upgrades take effect at once; a downgrade needs the count to fall hyst below the threshold.
  function automatic level_t classify_level(input level_t cur, input int unsigned c,
                                            input int unsigned mod_t = 4,
                                            input int unsigned high_t = 10,
                                            input int unsigned hyst = 1);
    return c >= high_t ? HIGH :
           (c >= mod_t && cur == LOW) ? MODERATE :
           cur == HIGH ? (c >= high_t - hyst ? HIGH : c >= mod_t - hyst ? MODERATE : LOW) :
           cur == MODERATE ? (c >= mod_t - hyst ? MODERATE : LOW) : LOW;
  endfunction
endpackage

// File: rtl/traffic_density_classifier_sensor.sv
// sensor_conditioner: 2-flop sync, debounce and one-cycle rising-edge pulse for one raw detector
//   clk, rst  clock, async active-high reset
//   i_raw     raw asynchronous detector level
//   o_rise    one-cycle pulse on each debounced rising edge
module sensor_conditioner #(
  parameter int unsigned DEBOUNCE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_rise
);
  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  logic r_s1, r_s2, r_db, r_rise;
  logic [CW-1:0] r_cnt;
  logic w_diff, w_flip;
  assign w_diff = r_s2 != r_db;
  // The DEBOUNCE-th consecutive differing sample commits the new level.
  assign w_flip = w_diff && r_cnt == CW'(DEBOUNCE - 1);
  assign o_rise = r_rise;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_db <= 1'b0;
      r_rise <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      r_cnt <= (w_diff && !w_flip) ? r_cnt + 1'b1 : '0;
      r_db <= w_flip ? r_s2 : r_db;
      r_rise <= w_flip && r_s2;
    end
endmodule

// File: rtl/traffic_density_classifier.sv
// traffic_density_classifier: windowed NS/EW vehicle counting with hysteretic LOW/MODERATE/HIGH levels
//   clk, rst                 clock, async active-high reset
//   en                       1 = count and advance window, 0 = freeze
//   veh_ns, veh_ew           raw detector inputs
//   traffic_NS, traffic_EW   registered density levels
//   level_valid              one-cycle pulse after each window close
//   count_ns, count_ew       counts of the last completed window
module traffic_density_classifier
  import traffic_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 128,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned MOD_THRESH = 4,
  parameter int unsigned HIGH_THRESH = 10,
  parameter int unsigned HYST = 1,
  parameter int unsigned DEBOUNCE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             veh_ns,
  input  logic             veh_ew,
  output logic [1:0]       traffic_NS,
  output logic [1:0]       traffic_EW,
  output logic             level_valid,
  output logic [CNT_W-1:0] count_ns,
  output logic [CNT_W-1:0] count_ew
);
  localparam int unsigned WW = WINDOW_CYCLES > 2 ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WW-1:0] LAST = WW'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAXC = '1;
  logic [WW-1:0] r_wcnt;
  logic [CNT_W-1:0] r_live_ns, r_live_ew, r_cnt_ns, r_cnt_ew;
  level_t r_lvl_ns, r_lvl_ew;
  logic r_valid;
  logic w_rise_ns, w_rise_ew, w_term;
  logic [CNT_W-1:0] w_next_ns, w_next_ew;
  sensor_conditioner #(.DEBOUNCE(DEBOUNCE)) u_ns (.clk(clk), .rst(rst), .i_raw(veh_ns), .o_rise(w_rise_ns));
  sensor_conditioner #(.DEBOUNCE(DEBOUNCE)) u_ew (.clk(clk), .rst(rst), .i_raw(veh_ew), .o_rise(w_rise_ew));
  assign w_term = en && r_wcnt == LAST;
  // Saturating next count; on the terminal cycle this is the closing count including that cycle's edge.
  assign w_next_ns = r_live_ns == MAXC ? MAXC : r_live_ns + CNT_W'(w_rise_ns);
  assign w_next_ew = r_live_ew == MAXC ? MAXC : r_live_ew + CNT_W'(w_rise_ew);
  assign traffic_NS = r_lvl_ns;
  assign traffic_EW = r_lvl_ew;
  assign level_valid = r_valid;
  assign count_ns = r_cnt_ns;
  assign count_ew = r_cnt_ew;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wcnt <= '0;
      r_live_ns <= '0;
      r_live_ew <= '0;
      r_cnt_ns <= '0;
      r_cnt_ew <= '0;
      r_lvl_ns <= LOW;
      r_lvl_ew <= LOW;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_term;
      if (en) begin
        r_wcnt <= w_term ? '0 : r_wcnt + 1'b1;
        r_live_ns <= w_term ? '0 : w_next_ns;
        r_live_ew <= w_term ? '0 : w_next_ew;
        if (w_term) begin
          r_cnt_ns <= w_next_ns;
          r_cnt_ew <= w_next_ew;
          r_lvl_ns <= classify_level(r_lvl_ns, 32'(w_next_ns), MOD_THRESH, HIGH_THRESH, HYST);
          r_lvl_ew <= classify_level(r_lvl_ew, 32'(w_next_ew), MOD_THRESH, HIGH_THRESH, HYST);
        end
      end
    end
endmodule

// File: tb/tb_traffic_density_classifier.sv
// tb_traffic_density_classifier: directed windows with hand-computed levels and counts
module tb_traffic_density_classifier;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, veh_ns = 1'b0, veh_ew = 1'b0;
  logic [1:0] t_ns, t_ew, t4_ns, t4_ew;
  logic lv, lv4;
  logic [7:0] c_ns, c_ew;
  logic [3:0] c4_ns, c4_ew;
  int n_pass = 0, n_tot = 0;
  always #5 clk = ~clk;
  traffic_density_classifier #(.WINDOW_CYCLES(128), .CNT_W(8), .MOD_THRESH(4), .HIGH_THRESH(10), .HYST(1), .DEBOUNCE(2)) dut (
    .clk(clk), .rst(rst), .en(en), .veh_ns(veh_ns), .veh_ew(veh_ew),
    .traffic_NS(t_ns), .traffic_EW(t_ew), .level_valid(lv), .count_ns(c_ns), .count_ew(c_ew));
  traffic_density_classifier #(.WINDOW_CYCLES(128), .CNT_W(4), .MOD_THRESH(4), .HIGH_THRESH(10), .HYST(1), .DEBOUNCE(2)) dut4 (
    .clk(clk), .rst(rst), .en(en), .veh_ns(veh_ns), .veh_ew(veh_ew),
    .traffic_NS(t4_ns), .traffic_EW(t4_ew), .level_valid(lv4), .count_ns(c4_ns), .count_ew(c4_ew));
  task automatic check(input string tag, input int got, input int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic wait_lv(output int k);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!lv && k < 400);
  endtask
  task automatic pulses(input int n_ns, input int n_ew, input int hi, input int lo);
    for (int i = 0; i < (n_ns > n_ew ? n_ns : n_ew); i++) begin
      @(negedge clk);
      veh_ns = i < n_ns;
      veh_ew = i < n_ew;
      repeat (hi) @(negedge clk);
      veh_ns = 1'b0;
      veh_ew = 1'b0;
      repeat (lo - 1) @(negedge clk);
    end
  endtask
  task automatic run_win(input string tag, input int n_ns, input int n_ew, input int hi,
                         input int e_tns, input int e_tew, input int e_cns, input int e_cew);
    int k;
    pulses(n_ns, n_ew, hi, 3);
    wait_lv(k);
    check({tag, "_lv"}, int'(lv), 1);
    check({tag, "_tns"}, int'(t_ns), e_tns);
    check({tag, "_tew"}, int'(t_ew), e_tew);
    check({tag, "_cns"}, int'(c_ns), e_cns);
    check({tag, "_cew"}, int'(c_ew), e_cew);
  endtask
  initial begin
    int k;
    pulses(6, 0, 3, 3);
    check("rst_tns", int'(t_ns), 0);
    check("rst_tew", int'(t_ew), 0);
    check("rst_lv", int'(lv), 0);
    check("rst_cns", int'(c_ns), 0);
    check("rst_cew", int'(c_ew), 0);
    @(negedge clk);
    veh_ns = 1'b0;
    rst = 1'b0;
    wait_lv(k);
    check("rst_first_lv_delay", k, 128);
    check("rst_first_tns", int'(t_ns), 0);
    check("rst_first_cns", int'(c_ns), 0);
    run_win("clean", 5, 0, 3, 1, 0, 5, 0);
    @(posedge clk);
    #1;
    check("lv_one_cycle", int'(lv), 0);
    run_win("glitch", 10, 0, 1, 0, 0, 0, 0);
    run_win("single", 1, 0, 3, 0, 0, 1, 0);
    run_win("hyst12", 12, 4, 3, 2, 1, 12, 4);
    run_win("hyst9", 9, 4, 3, 2, 1, 9, 4);
    run_win("hyst8", 8, 4, 3, 1, 1, 8, 4);
    run_win("hyst3", 3, 4, 3, 1, 1, 3, 4);
    run_win("hyst2", 2, 4, 3, 0, 1, 2, 4);
    run_win("sat20", 20, 0, 3, 2, 0, 20, 0);
    check("sat_c4", int'(c4_ns), 15);
    check("sat_t4", int'(t4_ns), 2);
    run_win("after_sat", 2, 0, 3, 0, 0, 2, 0);
    check("after_sat_c4", int'(c4_ns), 2);
    check("after_sat_t4", int'(t4_ns), 0);
    for (int n = 1; n <= 167; n++) begin
      @(negedge clk);
      en = !(n >= 30 && n < 70);
      veh_ns = (n >= 32 && n < 62 && (n - 32) % 6 < 3) || (n >= 164 && n < 167);
      if (n == 50) begin
        check("en0_hold_cns", int'(c_ns), 2);
        check("en0_lv", int'(lv), 0);
      end
    end
    wait_lv(k);
    check("en0_delay", k, 2);
    check("en0_lv_seen", int'(lv), 1);
    check("en0_term_cns", int'(c_ns), 1);
    check("en0_term_c4", int'(c4_ns), 1);
    check("en0_tns", int'(t_ns), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
